serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and sum width in bits; the legal range is 1 to 32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  SHALL be operand A, captured only when start is accepted.
REQ-006 b  input  WIDTH  SHALL be operand B, captured only when start is accepted.
REQ-007 busy  output  1  SHALL be high while an addition is in progress.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking sum/cout valid.
REQ-009 sum  output  WIDTH  SHALL carry the registered result bits (a+b) mod 2^WIDTH.
REQ-010 cout  output  1  SHALL carry the registered carry-out of a+b.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, ADD and DONE.
REQ-012 IDLE->ADD SHALL occur when start=1; the block latches a and b into shift registers, clears the carry flop to 0 and clears the bit counter to 0.
REQ-013 In ADD, each cycle SHALL consume the LSB of each shift register: bit = a0^b0^c, next c = (a0&b0)|(c&(a0^b0)), built as two half-adder stages plus OR.
REQ-014 In ADD, each result bit SHALL shift into a working register from the MSB side; both operand registers SHALL shift right by 1.
REQ-015 ADD SHALL last exactly WIDTH cycles, counted by a bit counter of width clog2(WIDTH+1).
REQ-016 ADD->DONE SHALL occur on the cycle in which the counter reaches WIDTH-1; on that edge sum <= final working register and cout <= final carry.
REQ-017 DONE SHALL last one cycle with done=1, then go to IDLE; if start=1 in DONE, it SHALL go directly to ADD with a new capture per REQ-012.
REQ-018 busy SHALL be 1 in ADD and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-019 Latency: for start sampled at edge k, busy SHALL be high over edges k+1..k+WIDTH and done high over cycle k+WIDTH+1.
REQ-020 start SHALL be ignored in ADD; the operand registers SHALL NOT change mid-operation.
REQ-021 sum and cout SHALL hold their last value until the next DONE entry and SHALL NOT change during ADD.
REQ-022 With WIDTH=1, ADD SHALL last one cycle; the counter SHALL NOT wrap or overflow for any legal WIDTH.
REQ-023 Overflow: the carry beyond the MSB SHALL appear only on cout; sum SHALL wrap modulo 2^WIDTH.

Reset
REQ-024 While rst_n=0, the FSM SHALL be IDLE and busy, done, sum, cout, the carry flop, the counter, and the operand and working registers SHALL be 0, regardless of clk.
REQ-025 Reset asserted mid-ADD SHALL abort the operation with no done pulse; after release, the block SHALL accept start on the first rising edge.

Verification
REQ-026 WIDTH=8, start with a=0x5A, b=0x3C -> busy high 8 cycles; done pulse 9 cycles after start; sum=0x96, cout=0.
REQ-027 a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-028 start held high with new a/b during ADD -> result matches the first operands only; the second start is not accepted until DONE.
REQ-029 start asserted in DONE with a=0x01, b=0x02 -> no IDLE cycle between; second done pulse 9 cycles later with sum=0x03.
REQ-030 rst_n pulsed low at ADD cycle 4 -> all outputs 0 immediately; no done pulse; a later start completes correctly.
REQ-031 WIDTH=1 exhaustive over 4 operand pairs, plus a WIDTH=8 random sweep of at least 1000 pairs -> {cout,sum} == a+b every time.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage reused over WIDTH cycles.
// Operands shift out LSB-first and the sum shifts in from the MSB side.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             cout_next;

  // Full adder built from two half adders and an OR.
  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_carry;
  assign ha1_s    = a_reg[0] ^ b_reg[0];
  assign ha1_c    = a_reg[0] & b_reg[0];
  assign ha2_s    = ha1_s ^ carry_reg;
  assign ha2_c    = ha1_s & carry_reg;
  assign fa_carry = ha1_c | ha2_c;

  // Shift form keeps WIDTH=1 legal: the new bit simply replaces the register.
  logic [WIDTH-1:0] work_shifted;
  assign work_shifted = (work_reg >> 1) | (WIDTH'(ha2_s) << (WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    work_next  = work_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum;
    cout_next  = cout;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          work_next  = '0;
          carry_next = 1'b0;
          cnt_next   = '0;
          state_next = ADD;
        end
      end

      ADD: begin
        busy       = 1'b1;
        a_next     = a_reg >> 1;
        b_next     = b_reg >> 1;
        work_next  = work_shifted;
        carry_next = fa_carry;
        if (cnt_reg == LAST_BIT) begin
          sum_next   = work_shifted;
          cout_next  = fa_carry;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        done = 1'b1;
        // Back-to-back start skips IDLE entirely.
        if (start) begin
          a_next     = a;
          b_next     = b;
          work_next  = '0;
          carry_next = 1'b0;
          cnt_next   = '0;
          state_next = ADD;
        end else begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      work_reg  <= work_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      sum       <= sum_next;
      cout      <= cout_next;
    end
  end

endmodule
